// File: rtl/csa_resolve_seq.sv
// Carry-save resolver: adds a sum/carry vector pair plus carry-in, CHUNK bits per
// cycle through a parallel-prefix slice, with the inter-slice carry held in a register.
module csa_resolve_seq #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum_i,
    input  logic [WIDTH-1:0] carry_i,
    input  logic             cin_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_o,
    output logic             cout_o
);
    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  sum_reg, sum_next;
    logic [WIDTH-1:0]  carry_vec_reg, carry_vec_next;
    logic              carry_reg, carry_next;
    logic [IDXW-1:0]   idx_reg, idx_next;
    logic [WIDTH-1:0]  result_reg, result_next;
    logic              cout_reg, cout_next;

    logic [CHUNK-1:0]  slice_a, slice_b, slice_half, slice_r;
    logic [CHUNK-1:0]  grp_g, grp_p, prev_g, prev_p;
    logic [CHUNK:0]    slice_c;
    logic              accept;

    assign slice_a = sum_reg[idx_reg*CHUNK +: CHUNK];
    assign slice_b = carry_vec_reg[idx_reg*CHUNK +: CHUNK];
    assign slice_half = slice_a ^ slice_b;

    // Kogge-Stone prefix: grp_g/grp_p[i] are group generate/propagate over bits [i:0].
    always_comb begin
        grp_g  = slice_a & slice_b;
        grp_p  = slice_half;
        prev_g = '0;
        prev_p = '0;
        for (int d = 1; d < CHUNK; d = d * 2) begin
            prev_g = grp_g;
            prev_p = grp_p;
            for (int i = d; i < CHUNK; i++) begin
                grp_g[i] = prev_g[i] | (prev_p[i] & prev_g[i-d]);
                grp_p[i] = prev_p[i] & prev_p[i-d];
            end
        end
    end

    assign slice_c[0] = carry_reg;
    generate
        for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
            assign slice_c[gi+1] = grp_g[gi] | (grp_p[gi] & carry_reg);
            assign slice_r[gi]   = slice_half[gi] ^ slice_c[gi];
        end
    endgenerate

    assign in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
    assign out_valid = (state_reg == DONE);
    assign result_o  = result_reg;
    assign cout_o    = cout_reg;
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_next     = state_reg;
        sum_next       = sum_reg;
        carry_vec_next = carry_vec_reg;
        carry_next     = carry_reg;
        idx_next       = idx_reg;
        result_next    = result_reg;
        cout_next      = cout_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = ADD;
                end
            end
            ADD: begin
                result_next[idx_reg*CHUNK +: CHUNK] = slice_r;
                carry_next = slice_c[CHUNK];
                idx_next   = idx_reg + 1'b1;
                if (idx_reg == IDXW'(N - 1)) begin
                    cout_next  = slice_c[CHUNK];
                    state_next = DONE;
                end
            end
            DONE: begin
                // Zero-bubble restart: a new pair is taken in the same cycle the result leaves.
                if (out_ready) begin
                    state_next = in_valid ? ADD : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (accept) begin
            sum_next       = sum_i;
            carry_vec_next = carry_i;
            carry_next     = cin_i;
            idx_next       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            sum_reg       <= '0;
            carry_vec_reg <= '0;
            carry_reg     <= 1'b0;
            idx_reg       <= '0;
            result_reg    <= '0;
            cout_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sum_reg       <= sum_next;
            carry_vec_reg <= carry_vec_next;
            carry_reg     <= carry_next;
            idx_reg       <= idx_next;
            result_reg    <= result_next;
            cout_reg      <= cout_next;
        end
    end
endmodule

// File: tb/tb_csa_resolve_seq.sv
// Directed and randomised checks of csa_resolve_seq (WIDTH=64, CHUNK=16).
module tb_csa_resolve_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] sum_i;
    logic [63:0] carry_i;
    logic        cin_i;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result_o;
    logic        cout_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    csa_resolve_seq #(.WIDTH(64), .CHUNK(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .sum_i(sum_i), .carry_i(carry_i), .cin_i(cin_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .result_o(result_o), .cout_o(cout_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    // Presents an operand pair at a negedge and returns just after the accepting edge.
    task automatic accept_op(input logic [63:0] s, input logic [63:0] c, input logic ci);
        @(negedge clk);
        in_valid = 1'b1; sum_i = s; carry_i = c; cin_i = ci;
        #1 chk("accept_ready", {64'd0, in_ready}, 65'd1);
        @(posedge clk);
    endtask

    // Called just after an accept edge; returns at the negedge where out_valid is seen,
    // with cnt = number of edges after the accept edge.
    task automatic wait_valid(input bit keep_valid, output int cnt);
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!keep_valid) in_valid = 1'b0;
            if (out_valid) break;
            @(posedge clk);
            cnt++;
            if (cnt > 40) begin
                chk("valid_timeout", 65'd0, 65'd1);
                break;
            end
        end
    endtask

    logic [64:0] exp_q[$];
    logic [64:0] golden;
    int          lat, cyc_a, sent, got, budget;
    bit          seen;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        sum_i = '0; carry_i = '0; cin_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", {64'd0, in_ready}, 65'd1);
        chk("rst_out_valid", {64'd0, out_valid}, 65'd0);
        chk("rst_result", {cout_o, result_o}, 65'd0);

        // Full carry ripple through every slice
        accept_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
        wait_valid(1'b0, lat);
        chk("ripple_lat", 65'(lat), 65'd4);
        chk("ripple_sum", {cout_o, result_o}, {1'b1, 64'd0});

        // Plain addition
        accept_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0);
        wait_valid(1'b0, lat);
        chk("plain_sum", {cout_o, result_o}, {1'b0, 64'h1234_5678_9ABC_DF00});

        // Backpressure: result held, new request ignored
        @(negedge clk);
        out_ready = 1'b0;
        accept_op(64'd5, 64'd7, 1'b1);
        wait_valid(1'b0, lat);
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                in_valid = 1'b1; sum_i = 64'hDEAD; carry_i = 64'hBEEF; cin_i = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            chk("bp_valid", {64'd0, out_valid}, 65'd1);
            chk("bp_in_ready", {64'd0, in_ready}, 65'd0);
            chk("bp_result", {cout_o, result_o}, 65'd13);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_idle_valid", {64'd0, out_valid}, 65'd0);
        chk("bp_idle_ready", {64'd0, in_ready}, 65'd1);
        chk("bp_hold_result", {cout_o, result_o}, 65'd13);

        // Back-to-back with zero bubble
        accept_op(64'd1, 64'd2, 1'b0);
        @(negedge clk);
        sum_i = 64'h8000_0000_0000_0000; carry_i = 64'h8000_0000_0000_0000; cin_i = 1'b0;
        @(posedge clk);
        wait_valid(1'b1, lat);
        lat = lat + 1;
        cyc_a = cyc;
        chk("b2b_a_lat", 65'(lat), 65'd4);
        chk("b2b_a_sum", {cout_o, result_o}, 65'd3);
        chk("b2b_a_ready", {64'd0, in_ready}, 65'd1);
        @(posedge clk);
        wait_valid(1'b0, lat);
        chk("b2b_b_lat", 65'(lat), 65'd4);
        chk("b2b_spacing", 65'(cyc - cyc_a), 65'd5);
        chk("b2b_b_sum", {cout_o, result_o}, {1'b1, 64'd0});

        // Reset during the 2nd ADD cycle
        accept_op(64'h1234, 64'h4321, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_valid", {64'd0, out_valid}, 65'd0);
        chk("mid_rst_ready", {64'd0, in_ready}, 65'd1);
        chk("mid_rst_result", {cout_o, result_o}, 65'd0);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("mid_rst_stale", {64'd0, seen}, 65'd0);

        // Random traffic with gaps and backpressure
        sent = 0; got = 0; budget = 0;
        while (got < 1000 && budget < 40000) begin
            @(negedge clk);
            budget++;
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && sent < 1000 && $urandom_range(0, 2) != 0) begin
                in_valid = 1'b1;
                sum_i    = {$urandom, $urandom};
                carry_i  = {$urandom, $urandom};
                cin_i    = 1'($urandom_range(0, 1));
            end
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_extra", 65'd1, 65'd0);
                end else begin
                    golden = exp_q.pop_front();
                    chk("rnd_sum", {cout_o, result_o}, golden);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({1'b0, sum_i} + {1'b0, carry_i} + 65'(cin_i));
                sent++;
                @(posedge clk);
                #1 in_valid = 1'b0;
            end
        end
        chk("rnd_sent", 65'(sent), 65'd1000);
        chk("rnd_got", 65'(got), 65'd1000);
        chk("rnd_queue", 65'(exp_q.size()), 65'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
